// File: rtl/ibex_obi_responder.sv
// ibex_obi_responder: memory-side responder for one Ibex OBI-style bus port.
// Grants requests, commits byte-enabled writes and samples read data at the grant edge, then
// returns in-order rvalid/rdata/err responses after a configurable minimum latency.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i   initiator request
//   gnt_o                 combinational grant
//   rvalid_o/rdata_o/err_o          response (rdata/err are 0 when rvalid_o is 0)
//   stall_i               suppresses grant
//   resp_hold_i           suppresses rvalid
//   outstanding_o         granted-but-unanswered count
//   proto_err_o           sticky initiator stability violation
module ibex_obi_responder #(
  parameter int unsigned MemWords       = 256,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1,
  parameter bit          ErrEnable      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i,
  input  logic        resp_hold_i,
  output logic [2:0]  outstanding_o,
  output logic        proto_err_o
);

  localparam int unsigned Aw     = $clog2(MemWords);
  localparam logic [2:0]  MaxCnt = 3'(MaxOutstanding);
  localparam logic [2:0]  LatCnt = 3'(RespLatency);

  logic [31:0] mem_q [MemWords];

  // Shift-register FIFO: entry 0 is always the head.
  logic [31:0] fifo_rdata_q [MaxOutstanding];
  logic [31:0] fifo_rdata_d [MaxOutstanding];
  logic        fifo_err_q   [MaxOutstanding];
  logic        fifo_err_d   [MaxOutstanding];
  logic [2:0]  fifo_age_q   [MaxOutstanding];
  logic [2:0]  fifo_age_d   [MaxOutstanding];
  logic [2:0]  aged         [MaxOutstanding];
  logic [2:0]  count_q, count_d, wr_idx;

  logic [Aw-1:0] word_idx;
  logic          out_of_range, full, push, pop;
  logic [31:0]   push_rdata;
  logic          unused_addr;

  // Protocol monitor state.
  logic        pend_q, pend_we_q, proto_err_q, pend_next, violation;
  logic [31:0] pend_addr_q, pend_wdata_q;
  logic [3:0]  pend_be_q;

  assign unused_addr  = ^addr_i[1:0];
  assign word_idx     = addr_i[Aw+1:2];
  assign out_of_range = ErrEnable && (addr_i[31:Aw+2] != '0);

  assign full  = (count_q >= MaxCnt);
  // A pop in the same cycle deliberately does not open a slot for this cycle's grant.
  assign gnt_o = req_i && !stall_i && !reset && (count_q < MaxCnt);
  assign push  = req_i && gnt_o;

  assign rvalid_o      = (count_q != 3'd0) && (fifo_age_q[0] >= LatCnt) && !resp_hold_i && !reset;
  assign pop           = rvalid_o;
  assign rdata_o       = rvalid_o ? fifo_rdata_q[0] : 32'h0;
  assign err_o         = rvalid_o ? fifo_err_q[0] : 1'b0;
  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

  assign push_rdata = (we_i || out_of_range) ? 32'h0 : mem_q[word_idx];

  always_comb begin
    for (int i = 0; i < MaxOutstanding; i++) begin
      aged[i] = (fifo_age_q[i] < LatCnt) ? fifo_age_q[i] + 3'd1 : fifo_age_q[i];
    end
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (pop) begin
        // Wrap-around source only feeds the slot vacated by the pop; its content is dead.
        fifo_rdata_d[i] = fifo_rdata_q[(i + 1) % MaxOutstanding];
        fifo_err_d[i]   = fifo_err_q[(i + 1) % MaxOutstanding];
        fifo_age_d[i]   = aged[(i + 1) % MaxOutstanding];
      end else begin
        fifo_rdata_d[i] = fifo_rdata_q[i];
        fifo_err_d[i]   = fifo_err_q[i];
        fifo_age_d[i]   = aged[i];
      end
    end
    wr_idx = pop ? count_q - 3'd1 : count_q;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (push && (3'(i) == wr_idx)) begin
        fifo_rdata_d[i] = push_rdata;
        fifo_err_d[i]   = out_of_range;
        fifo_age_d[i]   = 3'd1;
      end
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 3'd0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_rdata_q[i] <= 32'h0;
        fifo_err_q[i]   <= 1'b0;
        fifo_age_q[i]   <= 3'd0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_rdata_q[i] <= fifo_rdata_d[i];
        fifo_err_q[i]   <= fifo_err_d[i];
        fifo_age_q[i]   <= fifo_age_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MemWords; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push && we_i && !out_of_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // With no stall and room in the FIFO, only reset can refuse a request, so a request held
  // across the reset edge is the one that becomes pending.
  assign pend_next = req_i && !gnt_o && !stall_i && !full;
  assign violation = pend_q && (!req_i || (addr_i != pend_addr_q) || (we_i != pend_we_q) ||
                                (be_i != pend_be_q) || (pend_we_q && (wdata_i != pend_wdata_q)));

  // Captured without reset so a request presented during reset is still tracked.
  always_ff @(posedge clock) begin
    pend_q       <= pend_next;
    pend_addr_q  <= addr_i;
    pend_we_q    <= we_i;
    pend_be_q    <= be_i;
    pend_wdata_q <= wdata_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (violation) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/ibex_obi_responder.md
Name: ibex_obi_responder

Overview:
- Memory-side responder for one Ibex OBI-style bus port (instruction or data); the counterpart of the core's request initiator.
- Grants requests, performs byte-enabled writes into a small internal memory, and returns in-order rvalid/rdata/err responses with configurable latency and bounded outstanding depth.
- Used in simulation benches and bounded formal runs around ibex_top as a concrete, protocol-correct memory.
- Flags initiator stability violations.

Parameters:
MemWords, 256, number of 32-bit words in internal memory; power of two, >=4
MaxOutstanding, 2, maximum granted-but-unanswered requests; range 1..4
RespLatency, 1, minimum cycles from grant to rvalid; range 1..7
ErrEnable, 1, when 1 out-of-range accesses return err; when 0 the address wraps modulo MemWords

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
req_i  input  1  request from initiator
addr_i  input  32  byte address; bits [1:0] ignored
we_i  input  1  1 = write, 0 = read
be_i  input  4  byte enables (write only)
wdata_i  input  32  write data
gnt_o  output  1  grant, combinational
rvalid_o  output  1  response valid
rdata_o  output  32  read data (0 for writes/errors)
err_o  output  1  error response
stall_i  input  1  suppresses grant (bench/formal back-pressure)
resp_hold_i  input  1  suppresses rvalid (bench/formal response delay)
outstanding_o  output  3  current outstanding count
proto_err_o  output  1  sticky initiator protocol violation

Behaviour:
- Reset: synchronous, active-high. Clears the response FIFO, count, timers, proto_err_o and memory to 0. gnt_o, rvalid_o, rdata_o, err_o and outstanding_o are 0 in the cycle after reset deasserts.
- Grant: gnt_o = req_i && !stall_i && !reset && (count < MaxOutstanding).
  - A same-cycle pop does NOT free a slot for that cycle's grant (conservative).
- Transfer: occurs on the clock edge where req_i && gnt_o.
  - Range: word index = addr_i[log2(MemWords)+1:2].
  - Out of range when ErrEnable=1 and addr_i[31:log2(MemWords)+2] != 0.
  - In-range write: each byte k with be_i[k]=1 is updated. be_i=0000 is a legal no-op write.
  - In-range read: rdata is sampled from memory at the grant edge and stored in the FIFO entry.
  - Errored access: memory is unchanged; entry is stored with rdata=0, err=1.
  - Write response: rdata=0, err=0 (or err=1 if out of range).
- Response FIFO: depth MaxOutstanding, in-order. Each entry holds {rdata, err, age}.
  - age is loaded to 1 on push and increments each cycle, saturating at RespLatency.
- rvalid_o = head valid && head.age >= RespLatency && !resp_hold_i. Head pops whenever rvalid_o=1; the initiator cannot back-pressure responses.
  - With RespLatency=1 and no hold, a grant in cycle T gives rvalid in T+1.
  - Back-to-back grants give back-to-back responses.
- rdata_o and err_o equal the head fields when rvalid_o=1, else 0.
- Simultaneous push and pop: count unchanged; the new entry goes behind the head.
- Count: outstanding_o = count; it never exceeds MaxOutstanding. When full, gnt_o=0 until the cycle after a pop.
- Ordering hazard: a read granted after a write to the same word returns the new data. Both transfers are committed at their grant edges, in grant order.
- Protocol monitor: track a pending request (req_i=1 and gnt_o=0 in the previous cycle, excluding cycles where stall_i or a full FIFO was the only reason). In the next cycle, proto_err_o is set and stays set until reset if any of these hold:
  - req_i drops;
  - addr_i, we_i or be_i change;
  - wdata_i changes during a write.
- Reset mid-operation: pending responses are discarded, with no rvalid for them after reset. Memory is cleared.

Test Plan:
- Write then read: write addr=0x10, be=1111, wdata=0xDEADBEEF; then read 0x10 -> gnt same cycle as req; second rvalid has rdata=0xDEADBEEF, err=0; with RespLatency=1, each rvalid is 1 cycle after its grant.
- Byte enables: write 0x11223344 to 0x20, then be=0101 wdata=0xAABBCCDD, then read 0x20 -> rdata=0x11BB33DD.
- Outstanding limit: MaxOutstanding=2, resp_hold_i=1, req held for 3 reads -> gnt for the first two only, outstanding_o=2, third gnt=0. Release hold -> two rvalids in consecutive cycles; third gnt in the cycle after the first pop.
- Out-of-range: MemWords=256, read addr 0x400 -> rvalid with err=1, rdata=0. Write to 0x400 then read 0x0 -> rdata unchanged (0).
- Latency and hold: RespLatency=3, grant at T -> rvalid at T+3. With resp_hold_i=1 over T+3..T+5 -> rvalid at T+6, data intact.
- Protocol and reset: stall_i=0, FIFO not full, req with addr=0x8 is never granted in a cycle (forced via reset edge). Separately, change addr while pending -> proto_err_o=1 and stays until reset. Assert reset with 2 outstanding -> outstanding_o=0 and no rvalid afterward.
